// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch: owns the PC, issues single-outstanding word reads
// over req/ack, buffers up to two instructions for decode, and handles redirects.
module wiscsc15_fetch #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter int              OFFW     = 12,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [DW-1:0]      imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [DW-1:0]      inst,
    output logic [AW-1:0]      inst_pc,
    input  logic               redir_valid,
    input  logic               redir_pc_src,
    input  logic [AW-1:0]      redir_base,
    input  logic [OFFW-1:0]    redir_off,
    input  logic               stall
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DROP  = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_pc;
    logic          r_pending;
    logic [AW-1:0] r_req_addr;
    logic          r_head;
    logic [1:0]    r_count;
    logic [AW-1:0] r_buf_pc   [2];
    logic [DW-1:0] r_buf_inst [2];

    logic          w_redir;
    logic [AW-1:0] w_target;
    logic          w_pop;
    logic          w_space;
    logic          w_new_req;
    logic          w_ack;
    logic          w_push;
    logic          w_tail;

    assign w_redir  = redir_valid & redir_pc_src;
    assign w_target = redir_base + AW'(1) + {{(AW-OFFW){redir_off[OFFW-1]}}, redir_off};

    assign inst_valid = (r_count != 2'd0);
    assign w_pop      = inst_valid & inst_ready;
    assign w_space    = (r_count - {1'b0, w_pop}) < 2'd2;

    // A held request keeps its address even after a redirect moves the PC.
    assign w_new_req = (r_state == S_FETCH) & ~stall & w_space & ~w_redir;
    assign imem_req  = rst_n & (r_pending | w_new_req);
    assign imem_addr = r_pending ? r_req_addr : r_pc;

    assign w_ack  = imem_req & imem_ack;
    assign w_push = w_ack & (r_state == S_FETCH) & ~w_redir;
    assign w_tail = r_head + r_count[0];

    assign inst    = inst_valid ? r_buf_inst[r_head] : '0;
    assign inst_pc = inst_valid ? r_buf_pc[r_head]   : '0;

    // NOTE: buffer storage is not reset; r_count alone decides what is valid,
    // and the output muxes force zeros while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[w_tail]   <= r_pc;
            r_buf_inst[w_tail] <= imem_rdata;
        end
    end

    // NOTE: all state here is clocked, so every assignment is non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_pending  <= 1'b0;
            r_req_addr <= RESET_PC;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
        end else if (w_redir) begin
            r_pc    <= w_target;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            if (imem_req && !imem_ack) begin
                r_state    <= S_DROP;
                r_pending  <= 1'b1;
                r_req_addr <= imem_addr;
            end else begin
                r_state   <= S_FETCH;
                r_pending <= 1'b0;
            end
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        r_pc      <= r_pc + AW'(1);
                        r_pending <= 1'b0;
                    end else if (imem_req) begin
                        r_pending  <= 1'b1;
                        r_req_addr <= imem_addr;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        r_state   <= S_FETCH;
                        r_pending <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/wiscsc15_fetch.md
Name: wiscsc15_fetch

Overview:
Instruction fetch unit for the WISC-SC15 core. It owns the PC and issues word reads to instruction memory over a req/ack handshake. Fetched instructions go into a 2-entry buffer and are presented to the decode/control stage (wiscsc15_ctrl input side) with a valid/ready handshake. Taken branches and calls from the control path redirect the PC (pc_src = PC_SRC_OFF) and flush stale instructions.

Parameters:
AW, 16, instruction address width (word addressed)
DW, 16, instruction width; opcode is inst[DW-1:DW-4]
OFFW, 12, width of the signed PC offset carried in the instruction
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request to instruction memory
imem_addr  out  AW  word address of the request
imem_ack  in  1  memory accepts the request and returns data this cycle
imem_rdata  in  DW  instruction word, valid when imem_req & imem_ack
inst_valid  out  1  inst/inst_pc hold a valid instruction
inst_ready  in  1  decode consumes the head instruction
inst  out  DW  head instruction word to decode
inst_pc  out  AW  address of the head instruction
redir_valid  in  1  control path requests a PC redirect this cycle
redir_pc_src  in  1  0 = PC_SRC_NOM (ignored), 1 = PC_SRC_OFF (taken)
redir_base  in  AW  PC of the branching instruction
redir_off  in  OFFW  signed word offset from the instruction
stall  in  1  freeze new requests (outstanding request still completes)

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, buffer empty, state FETCH, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Redirect taken = redir_valid & redir_pc_src. target = redir_base + 1 + sign_extend(redir_off), modulo 2^AW (wraps, no overflow flag).
- Buffer: 2-entry FIFO of {pc, inst}. inst_valid = count!=0; inst/inst_pc = head entry (0 when empty). Pop when inst_valid & inst_ready.
- At most one outstanding memory request. imem_req and imem_addr held stable from assertion until the cycle with imem_ack. Data is captured in the ack cycle. Latency 0 (same-cycle ack) to unbounded.
- Space rule: request asserted only when count - pop_this_cycle < 2; a capture in the ack cycle must never overflow. A simultaneous push and pop leaves count unchanged.
- States:
  FETCH: imem_req = !stall & space & !redirect_taken. On ack: push {pc, rdata}, pc <= pc+1 (wraps at 2^AW).
  DROP: a request was outstanding when the redirect hit. imem_req stays high at the old address until ack; the data is discarded; then go to FETCH.
- Redirect taken (any state): buffer flushed (count=0, inst_valid=0 next cycle), pc <= target.
  - If a request is in flight without ack this cycle: go to DROP.
  - If ack occurs in the same cycle: discard that data and go to FETCH.
  - A pop in the same cycle is still legal; flush wins.
  - Redirect while in DROP: update pc to the new target, remain in DROP.
- redir_valid with redir_pc_src=0: no effect.
- stall: suppresses new requests only. It does not drop an outstanding req, and does not block pops or redirects.
- Reset mid-request: imem_req drops immediately (async); memory must tolerate the abandoned request.

Test Plan:
- Reset then run, ack every cycle, inst_ready=1: addresses 0,1,2,3 issued. Decode sees inst_pc 0,1,2,3 with matching imem_rdata (e.g. 0x1000 = ADD R0,R0,R0). First inst_valid on the cycle after the first ack.
- inst_ready=0 with constant ack: exactly 2 instructions buffered, imem_req then deasserts. Set inst_ready=1: pops at pc 0 then 1, fetch resumes at addr 2, no loss or duplication.
- Delayed ack, 3 cycles: imem_addr stable at 5 throughout. stall asserted mid-wait: request still completes, next request held until stall drops.
- Redirect with redir_base=0x0010, redir_off=0xFFE (-2), request at addr 0x12 outstanding: enter DROP, discard the 0x12 data, next imem_addr=0x000F. Buffer empty meanwhile.
- Redirect coincident with ack and pop: ack data dropped, buffer empty, next address = target. Also cover redir_base=0xFFFF, redir_off=0 -> target 0x0000 (wrap).
- Async reset asserted while imem_req=1 in DROP: all outputs reach reset values before the next clk edge. Fetch restarts at RESET_PC.
